amo_ctrl: RTL and testbench
===========================

Name: amo_ctrl

Overview:
Sequencer for RV32A atomic instructions. It sits between the core's memory stage and the data-bus port. It runs the read-modify-write sequence for AMO* instructions through an internally instantiated atomic ALU, and it runs LR.W/SC.W with a single-entry reservation. Exactly one atomic transaction is in flight at a time.

Parameters:
XLEN, 32, data/address width
RESV_GRAN, 2, reservation granule: address bits [XLEN-1:RESV_GRAN] are compared

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
i_req  input  1  atomic request valid; sampled only in IDLE
i_funct5  input  5  instr[31:27]: AMOADD 00000, AMOSWAP 00001, LR 00010, SC 00011, AMOXOR 00100, AMOOR 01000, AMOAND 01100, AMOMIN 10000, AMOMAX 10100, AMOMINU 11000, AMOMAXU 11100
i_addr  input  XLEN  rs1 effective address
i_wdata  input  XLEN  rs2 operand
i_resv_clr  input  1  clear reservation (trap/xRET)
i_st_snoop  input  1  ordinary store committing this cycle
i_st_addr  input  XLEN  address of snooped store
o_busy  output  1  high whenever state != IDLE
o_ack  output  1  one-cycle completion pulse
o_rdata  output  XLEN  rd writeback value, valid with o_ack
o_err  output  1  access fault, valid with o_ack
o_mem_req  output  1  bus request
o_mem_we  output  1  1 = write
o_mem_addr  output  XLEN  word address
o_mem_wdata  output  XLEN  write data
i_mem_ack  input  1  bus transfer done (may assert in the same cycle as o_mem_req)
i_mem_err  input  1  bus fault, qualified by i_mem_ack
i_mem_rdata  input  XLEN  read data, valid with i_mem_ack

Behaviour:
- Reset: state IDLE; reservation invalid. o_busy, o_ack, o_err, o_mem_req, o_mem_we = 0; o_rdata, o_mem_addr, o_mem_wdata = 0.
- States: IDLE, READ, WRITE, RESP.
- IDLE + i_req: latch funct5, addr, wdata, then branch as follows.
  - addr[1:0] != 0 or unknown funct5: go to RESP with o_err=1. No bus access.
  - LR or AMO*: go to READ.
  - SC: if the reservation is valid and the granule matches, go to WRITE with wdata = rs2 and result 0. Otherwise go to RESP with result 1 and no bus access.
  - Every SC invalidates the reservation, whether it passes or fails.
- READ: o_mem_req=1, we=0. Address is held stable until i_mem_ack.
  - On ack with err: go to RESP with o_err=1.
  - LR: loaded value becomes the result; set the reservation (valid, addr); go to RESP.
  - AMO*: latch loaded value L; register the ALU result (s1 = rs2, s2 = L, op = funct5) as the write data; go to WRITE.
- WRITE: o_mem_req=1, we=1, with registered wdata. Hold until ack, then go to RESP. On ack with err, set o_err=1.
- AMO result equals L, the pre-modification memory value.
- RESP: o_ack=1 for exactly one cycle, with o_rdata and o_err valid; return to IDLE. o_rdata holds its value until the next o_ack.
- Bus outputs are registered. o_mem_req drops in the cycle after the ack edge.
- Latency with zero-wait bus (ack in the same cycle as req), measured from the accept edge to the o_ack high cycle: AMO 3 cycles, LR 2, SC-success 2, SC-fail or fault 1.
- Reservation is cleared by any of the following; a clear has priority over an LR set in the same cycle:
  - i_resv_clr;
  - i_st_snoop with a matching granule;
  - any SC;
  - an AMO write ack to a matching granule.
- i_req outside IDLE is ignored. The requester must hold i_req until o_ack.
- rst asserted in READ/WRITE: next state IDLE, o_mem_req=0, no o_ack, reservation invalid. The bus side must tolerate the abandoned request.
- ALU arithmetic is XLEN-bit. MIN/MAX are signed; MINU/MAXU are unsigned; ADD wraps modulo 2^XLEN.

Test Plan:
- Zero-wait AMOADD: mem[0x100]=0x7FFFFFFF, rs2=1 -> read, then write 0x80000000; o_rdata=0x7FFFFFFF; o_ack 3 cycles after accept.
- AMOMIN vs AMOMINU: mem=0xFFFFFFFF, rs2=5 -> AMOMIN writes 0xFFFFFFFF; AMOMINU writes 5. Both return 0xFFFFFFFF.
- LR 0x200, then SC 0x200 rs2=0xAB -> SC writes 0xAB, o_rdata=0. A second SC to 0x200 -> o_rdata=1, no o_mem_req.
- LR 0x200, i_st_snoop to 0x200, then SC -> fail (1). Repeat with the snoop to 0x204 -> success (0).
- Misaligned AMOSWAP at 0x102 -> o_err=1 one cycle after accept, no bus activity. READ acked with i_mem_err -> o_err=1, no WRITE issued.
- 3-wait-state bus: addr/wdata/we stay stable across the waits. rst asserted during WRITE -> IDLE next cycle, no o_ack, subsequent SC fails.

Source files
------------

// File: rtl/amo_ctrl.sv
// RV32A atomic sequencer: AMO read-modify-write and LR/SC with a single-entry
// reservation, one transaction in flight, registered data-bus port.

module amo_alu #(
   parameter int XLEN = 32
) (
   input  logic [4:0]      op,
   input  logic [XLEN-1:0] s1,
   input  logic [XLEN-1:0] s2,
   output logic [XLEN-1:0] result
);
   always_comb begin
      result = s2;
      case (op)
         5'b00000: result = s1 + s2;
         5'b00001: result = s1;
         5'b00100: result = s1 ^ s2;
         5'b01000: result = s1 | s2;
         5'b01100: result = s1 & s2;
         5'b10000: result = ($signed(s1) < $signed(s2)) ? s1 : s2;
         5'b10100: result = ($signed(s1) > $signed(s2)) ? s1 : s2;
         5'b11000: result = (s1 < s2) ? s1 : s2;
         5'b11100: result = (s1 > s2) ? s1 : s2;
         default:  result = s2;
      endcase
   end
endmodule

module amo_ctrl #(
   parameter int XLEN      = 32,
   parameter int RESV_GRAN = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            i_req,
   input  logic [4:0]      i_funct5,
   input  logic [XLEN-1:0] i_addr,
   input  logic [XLEN-1:0] i_wdata,
   input  logic            i_resv_clr,
   input  logic            i_st_snoop,
   input  logic [XLEN-1:0] i_st_addr,
   output logic            o_busy,
   output logic            o_ack,
   output logic [XLEN-1:0] o_rdata,
   output logic            o_err,
   output logic            o_mem_req,
   output logic            o_mem_we,
   output logic [XLEN-1:0] o_mem_addr,
   output logic [XLEN-1:0] o_mem_wdata,
   input  logic            i_mem_ack,
   input  logic            i_mem_err,
   input  logic [XLEN-1:0] i_mem_rdata
);
   localparam logic [4:0] F_LR = 5'b00010;
   localparam logic [4:0] F_SC = 5'b00011;

   typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

   state_t                state_reg, state_next;
   logic [4:0]            funct5_reg, funct5_next;
   logic [XLEN-1:0]       operand_reg, operand_next;
   logic [XLEN-1:RESV_GRAN] gran_reg, gran_next;
   logic [XLEN-1:0]       load_reg, load_next;
   logic [XLEN-1:0]       rdata_reg, rdata_next;
   logic                  err_reg, err_next;
   logic                  mem_req_reg, mem_req_next;
   logic                  mem_we_reg, mem_we_next;
   logic [XLEN-1:0]       mem_addr_reg, mem_addr_next;
   logic [XLEN-1:0]       mem_wdata_reg, mem_wdata_next;
   logic                  resv_valid_reg, resv_valid_next;
   logic [XLEN-1:RESV_GRAN] resv_addr_reg, resv_addr_next;
   logic                  resv_clr;
   logic                  resv_set;
   logic [XLEN-1:0]       alu_result;
   logic                  lint_unused;

   // Byte-offset bits of the snooped address never take part in granule matching.
   assign lint_unused = ^i_st_addr[RESV_GRAN-1:0];

   function automatic logic known_op(input logic [4:0] f);
      case (f)
         5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b01000,
         5'b01100, 5'b10000, 5'b10100, 5'b11000, 5'b11100: known_op = 1'b1;
         default: known_op = 1'b0;
      endcase
   endfunction

   amo_alu #(.XLEN(XLEN)) u_alu (
      .op     (funct5_reg),
      .s1     (operand_reg),
      .s2     (i_mem_rdata),
      .result (alu_result)
   );

   always_comb begin
      state_next     = state_reg;
      funct5_next    = funct5_reg;
      operand_next   = operand_reg;
      gran_next      = gran_reg;
      load_next      = load_reg;
      rdata_next     = rdata_reg;
      err_next       = err_reg;
      mem_req_next   = mem_req_reg;
      mem_we_next    = mem_we_reg;
      mem_addr_next  = mem_addr_reg;
      mem_wdata_next = mem_wdata_reg;
      resv_set       = 1'b0;
      resv_clr       = i_resv_clr |
                       (i_st_snoop && (i_st_addr[XLEN-1:RESV_GRAN] == resv_addr_reg));

      case (state_reg)
         IDLE: begin
            if (i_req) begin
               funct5_next  = i_funct5;
               operand_next = i_wdata;
               gran_next    = i_addr[XLEN-1:RESV_GRAN];
               err_next     = 1'b0;
               if (i_funct5 == F_SC) resv_clr = 1'b1;
               if ((i_addr[1:0] != 2'b00) || !known_op(i_funct5)) begin
                  err_next   = 1'b1;
                  rdata_next = '0;
                  state_next = RESP;
               end else if (i_funct5 == F_SC) begin
                  if (resv_valid_reg && (i_addr[XLEN-1:RESV_GRAN] == resv_addr_reg)) begin
                     load_next      = '0;
                     mem_req_next   = 1'b1;
                     mem_we_next    = 1'b1;
                     mem_addr_next  = i_addr;
                     mem_wdata_next = i_wdata;
                     state_next     = WRITE;
                  end else begin
                     rdata_next = {{(XLEN-1){1'b0}}, 1'b1};
                     state_next = RESP;
                  end
               end else begin
                  mem_req_next  = 1'b1;
                  mem_we_next   = 1'b0;
                  mem_addr_next = i_addr;
                  state_next    = READ;
               end
            end
         end
         READ: begin
            if (i_mem_ack) begin
               if (i_mem_err) begin
                  err_next     = 1'b1;
                  rdata_next   = '0;
                  mem_req_next = 1'b0;
                  state_next   = RESP;
               end else if (funct5_reg == F_LR) begin
                  rdata_next   = i_mem_rdata;
                  resv_set     = 1'b1;
                  mem_req_next = 1'b0;
                  state_next   = RESP;
               end else begin
                  // Request stays up so the write follows the read back to back.
                  load_next      = i_mem_rdata;
                  mem_wdata_next = alu_result;
                  mem_we_next    = 1'b1;
                  state_next     = WRITE;
               end
            end
         end
         WRITE: begin
            if (i_mem_ack) begin
               mem_req_next = 1'b0;
               mem_we_next  = 1'b0;
               rdata_next   = load_reg;
               err_next     = i_mem_err;
               state_next   = RESP;
               if ((funct5_reg != F_SC) && (gran_reg == resv_addr_reg)) resv_clr = 1'b1;
            end
         end
         RESP: state_next = IDLE;
         default: state_next = IDLE;
      endcase

      resv_valid_next = resv_valid_reg;
      resv_addr_next  = resv_addr_reg;
      if (resv_clr) begin
         resv_valid_next = 1'b0;
      end else if (resv_set) begin
         resv_valid_next = 1'b1;
         resv_addr_next  = gran_reg;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= IDLE;
         funct5_reg     <= '0;
         operand_reg    <= '0;
         gran_reg       <= '0;
         load_reg       <= '0;
         rdata_reg      <= '0;
         err_reg        <= 1'b0;
         mem_req_reg    <= 1'b0;
         mem_we_reg     <= 1'b0;
         mem_addr_reg   <= '0;
         mem_wdata_reg  <= '0;
         resv_valid_reg <= 1'b0;
         resv_addr_reg  <= '0;
      end else begin
         state_reg      <= state_next;
         funct5_reg     <= funct5_next;
         operand_reg    <= operand_next;
         gran_reg       <= gran_next;
         load_reg       <= load_next;
         rdata_reg      <= rdata_next;
         err_reg        <= err_next;
         mem_req_reg    <= mem_req_next;
         mem_we_reg     <= mem_we_next;
         mem_addr_reg   <= mem_addr_next;
         mem_wdata_reg  <= mem_wdata_next;
         resv_valid_reg <= resv_valid_next;
         resv_addr_reg  <= resv_addr_next;
      end
   end

   assign o_busy      = (state_reg != IDLE);
   assign o_ack       = (state_reg == RESP);
   assign o_err       = (state_reg == RESP) && err_reg;
   assign o_rdata     = rdata_reg;
   assign o_mem_req   = mem_req_reg;
   assign o_mem_we    = mem_we_reg;
   assign o_mem_addr  = mem_addr_reg;
   assign o_mem_wdata = mem_wdata_reg;
endmodule

// File: tb/tb_amo_ctrl.sv
// Randomized bench for amo_ctrl: wait-state bus memory plus a transaction-level
// model of memory and the LR/SC reservation.

module tb_amo_ctrl;
   localparam logic [4:0] F_ADD  = 5'b00000, F_SWAP = 5'b00001, F_LR   = 5'b00010;
   localparam logic [4:0] F_SC   = 5'b00011, F_XOR  = 5'b00100, F_OR   = 5'b01000;
   localparam logic [4:0] F_AND  = 5'b01100, F_MIN  = 5'b10000, F_MAX  = 5'b10100;
   localparam logic [4:0] F_MINU = 5'b11000, F_MAXU = 5'b11100, F_BAD  = 5'b00101;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        i_req = 1'b0;
   logic [4:0]  i_funct5 = '0;
   logic [31:0] i_addr = '0, i_wdata = '0;
   logic        i_resv_clr = 1'b0, i_st_snoop = 1'b0;
   logic [31:0] i_st_addr = '0;
   logic        o_busy, o_ack, o_err, o_mem_req, o_mem_we;
   logic [31:0] o_rdata, o_mem_addr, o_mem_wdata;
   logic        i_mem_ack, i_mem_err;
   logic [31:0] i_mem_rdata;

   always #5 clk = ~clk;

   amo_ctrl #(.XLEN(32), .RESV_GRAN(2)) dut (
      .clk(clk), .rst(rst), .i_req(i_req), .i_funct5(i_funct5), .i_addr(i_addr),
      .i_wdata(i_wdata), .i_resv_clr(i_resv_clr), .i_st_snoop(i_st_snoop),
      .i_st_addr(i_st_addr), .o_busy(o_busy), .o_ack(o_ack), .o_rdata(o_rdata),
      .o_err(o_err), .o_mem_req(o_mem_req), .o_mem_we(o_mem_we),
      .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .i_mem_ack(i_mem_ack),
      .i_mem_err(i_mem_err), .i_mem_rdata(i_mem_rdata)
   );

   // ---------------- bus-side memory with programmable wait states
   logic [31:0] bus_mem [0:255];
   logic [31:0] model_mem [0:255];
   logic [31:0] seed = 32'h1234_5678;
   logic        mem_init = 1'b0;
   logic        poke_en = 1'b0;
   logic [7:0]  poke_idx = '0;
   logic [31:0] poke_val = '0;
   int          bus_waits = 0;
   int          wait_cnt = 0;
   int          xfer_cnt = 0;
   int          n_checks = 0;
   int          n_pass = 0;

   function automatic logic [31:0] init_val(input int i, input logic [31:0] s);
      return (i * 32'h9E37_79B1) ^ s;
   endfunction

   assign i_mem_ack   = o_mem_req && (wait_cnt >= bus_waits);
   assign i_mem_err   = i_mem_ack && (o_mem_addr[9:8] == 2'b11);
   assign i_mem_rdata = bus_mem[o_mem_addr[9:2]];

   always @(posedge clk) begin
      if (rst || !o_mem_req || i_mem_ack) wait_cnt <= 0;
      else wait_cnt <= wait_cnt + 1;
      if (mem_init) for (int i = 0; i < 256; i++) bus_mem[i] <= init_val(i, seed);
      if (poke_en) bus_mem[poke_idx] <= poke_val;
      if (o_mem_req && i_mem_ack) begin
         xfer_cnt <= xfer_cnt + 1;
         if (o_mem_we && !i_mem_err) bus_mem[o_mem_addr[9:2]] <= o_mem_wdata;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%h exp=%h", tag, got, exp);
   endtask

   // A stalled request must keep address, data and direction unchanged.
   logic        hold_p = 1'b0;
   logic [31:0] s_addr, s_wdata;
   logic [1:0]  s_ctl;
   always @(negedge clk) begin
      if (hold_p) begin
         check("hold_addr", o_mem_addr, s_addr);
         check("hold_wdata", o_mem_wdata, s_wdata);
         check("hold_ctl", {30'd0, o_mem_req, o_mem_we}, {30'd0, s_ctl});
      end
      hold_p  = o_mem_req && !i_mem_ack && !rst;
      s_addr  = o_mem_addr;
      s_wdata = o_mem_wdata;
      s_ctl   = {o_mem_req, o_mem_we};
   end

   // ---------------- transaction-level reference model
   logic        m_resv_v = 1'b0;
   logic [31:0] m_resv_a = '0;

   task automatic model_txn(input logic [4:0] f, input logic [31:0] a, input logic [31:0] wd,
                            input int w, output logic [31:0] e_rdata, output logic e_err,
                            output int e_xf, output int e_lat);
      logic        fault, known, hit;
      logic [31:0] l, n;
      fault = (a[9:8] == 2'b11);
      known = f inside {F_ADD, F_SWAP, F_LR, F_SC, F_XOR, F_OR, F_AND,
                        F_MIN, F_MAX, F_MINU, F_MAXU};
      hit   = m_resv_v && (a[31:2] == m_resv_a[31:2]);
      e_rdata = 0; e_err = 0; e_xf = 0; e_lat = 1;
      if (f == F_SC) m_resv_v = 1'b0;
      if (a[1:0] != 0 || !known) begin
         e_err = 1;
      end else if (f == F_SC) begin
         if (hit) begin
            e_xf = 1; e_lat = 2 + w;
            if (fault) e_err = 1; else model_mem[a[9:2]] = wd;
         end else begin
            e_rdata = 1;
         end
      end else if (fault) begin
         e_err = 1; e_xf = 1; e_lat = 2 + w;
      end else if (f == F_LR) begin
         e_rdata = model_mem[a[9:2]]; e_xf = 1; e_lat = 2 + w;
         m_resv_v = 1'b1; m_resv_a = a;
      end else begin
         l = model_mem[a[9:2]];
         case (f)
            F_ADD:   n = l + wd;
            F_SWAP:  n = wd;
            F_XOR:   n = l ^ wd;
            F_OR:    n = l | wd;
            F_AND:   n = l & wd;
            F_MIN:   n = (int'(wd) < int'(l)) ? wd : l;
            F_MAX:   n = (int'(wd) > int'(l)) ? wd : l;
            F_MINU:  n = (wd < l) ? wd : l;
            default: n = (wd > l) ? wd : l;
         endcase
         model_mem[a[9:2]] = n;
         e_rdata = l; e_xf = 2; e_lat = 3 + 2 * w;
         if (a[31:2] == m_resv_a[31:2]) m_resv_v = 1'b0;
      end
   endtask

   // ---------------- stimulus helpers
   task automatic poke(input logic [31:0] a, input logic [31:0] v);
      @(posedge clk); #1;
      poke_en = 1'b1; poke_idx = a[9:2]; poke_val = v;
      @(posedge clk); #1;
      poke_en = 1'b0;
      model_mem[a[9:2]] = v;
   endtask

   task automatic side_evt(input logic [31:0] a, input logic clr);
      @(posedge clk); #1;
      i_st_snoop = !clr; i_resv_clr = clr; i_st_addr = a;
      @(posedge clk); #1;
      i_st_snoop = 1'b0; i_resv_clr = 1'b0;
      if (clr || a[31:2] == m_resv_a[31:2]) m_resv_v = 1'b0;
   endtask

   task automatic run_txn(input logic [4:0] f, input logic [31:0] a, input logic [31:0] wd,
                          input int w, output logic [31:0] got);
      logic [31:0] e_rdata;
      logic        e_err, seen;
      int          e_xf, e_lat, lat, xf0;
      model_txn(f, a, wd, w, e_rdata, e_err, e_xf, e_lat);
      @(posedge clk); #1;
      bus_waits = w; xf0 = xfer_cnt;
      i_req = 1'b1; i_funct5 = f; i_addr = a; i_wdata = wd;
      lat = 0; seen = 1'b0;
      while (!seen && lat < 40) begin
         @(posedge clk); #1;
         lat++;
         if (lat == 1) check("busy", {31'd0, o_busy}, 32'd1);
         if (o_ack) seen = 1'b1;
      end
      i_req = 1'b0;
      check("ack_seen", {31'd0, seen}, 32'd1);
      check("latency", lat, e_lat);
      check("err", {31'd0, o_err}, {31'd0, e_err});
      if (!e_err) check("rdata", o_rdata, e_rdata);
      check("xfers", xfer_cnt - xf0, e_xf);
      check("mem", bus_mem[a[9:2]], model_mem[a[9:2]]);
      got = o_rdata;
      $display("txn f=%b addr=%h wd=%h waits=%0d rdata=%h err=%0d lat=%0d",
               f, a, wd, w, o_rdata, o_err, lat);
      @(posedge clk); #1;
      check("ack_pulse", {31'd0, o_ack}, 32'd0);
      check("idle", {31'd0, o_busy}, 32'd0);
   endtask

   logic [31:0] r;
   logic [4:0]  ops [0:12];
   logic [31:0] addrs [0:7];
   int          k;

   initial begin
      ops = '{F_ADD, F_SWAP, F_LR, F_SC, F_XOR, F_OR, F_AND, F_MIN,
              F_MAX, F_MINU, F_MAXU, F_LR, F_BAD};
      addrs = '{32'h100, 32'h104, 32'h200, 32'h204, 32'h300, 32'h102, 32'h201, 32'h200};
      seed = $urandom;
      for (int i = 0; i < 256; i++) model_mem[i] = init_val(i, seed);
      mem_init = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      mem_init = 1'b0;
      check("rst_busy", {31'd0, o_busy}, 32'd0);
      check("rst_ack", {31'd0, o_ack}, 32'd0);
      check("rst_err", {31'd0, o_err}, 32'd0);
      check("rst_req", {30'd0, o_mem_req, o_mem_we}, 32'd0);
      check("rst_rdata", o_rdata, 32'd0);
      check("rst_maddr", o_mem_addr, 32'd0);
      check("rst_mwdata", o_mem_wdata, 32'd0);
      rst = 1'b0;

      poke(32'h100, 32'h7FFF_FFFF);
      run_txn(F_ADD, 32'h100, 32'd1, 0, r);
      check("amoadd_ret", r, 32'h7FFF_FFFF);
      check("amoadd_mem", bus_mem[8'h40], 32'h8000_0000);
      poke(32'h104, 32'hFFFF_FFFF);
      run_txn(F_MIN, 32'h104, 32'd5, 0, r);
      check("amomin_mem", bus_mem[8'h41], 32'hFFFF_FFFF);
      run_txn(F_MINU, 32'h104, 32'd5, 0, r);
      check("amominu_ret", r, 32'hFFFF_FFFF);
      check("amominu_mem", bus_mem[8'h41], 32'd5);

      run_txn(F_LR, 32'h200, 32'd0, 0, r);
      run_txn(F_SC, 32'h200, 32'hAB, 0, r);
      check("sc_ok", r, 32'd0);
      run_txn(F_SC, 32'h200, 32'hCD, 0, r);
      check("sc_again", r, 32'd1);
      run_txn(F_LR, 32'h200, 32'd0, 0, r);
      side_evt(32'h200, 1'b0);
      run_txn(F_SC, 32'h200, 32'h11, 0, r);
      check("sc_snooped", r, 32'd1);
      run_txn(F_LR, 32'h200, 32'd0, 0, r);
      side_evt(32'h204, 1'b0);
      run_txn(F_SC, 32'h200, 32'h22, 0, r);
      check("sc_other_snoop", r, 32'd0);

      run_txn(F_SWAP, 32'h102, 32'h5, 0, r);
      run_txn(F_ADD, 32'h300, 32'h5, 0, r);
      run_txn(F_XOR, 32'h204, 32'hA5A5_0F0F, 3, r);

      // Abandon an AMO in its write phase; the reservation must not survive.
      run_txn(F_LR, 32'h200, 32'd0, 0, r);
      @(posedge clk); #1;
      bus_waits = 3; i_req = 1'b1; i_funct5 = F_ADD; i_addr = 32'h204; i_wdata = 32'd7;
      k = 0;
      while (!o_mem_we && k < 20) begin
         @(posedge clk); #1;
         k++;
      end
      check("reach_write", {31'd0, o_mem_we}, 32'd1);
      rst = 1'b1; i_req = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      check("abort_ack", {31'd0, o_ack}, 32'd0);
      check("abort_busy", {31'd0, o_busy}, 32'd0);
      check("abort_req", {31'd0, o_mem_req}, 32'd0);
      m_resv_v = 1'b0;
      repeat (2) begin
         @(posedge clk); #1;
         check("abort_noack", {31'd0, o_ack}, 32'd0);
      end
      check("abort_mem", bus_mem[8'h81], model_mem[8'h81]);
      run_txn(F_SC, 32'h200, 32'h33, 0, r);
      check("sc_after_rst", r, 32'd1);

      for (int t = 0; t < 150; t++) begin
         k = $urandom_range(0, 7);
         if (k == 0) side_evt(addrs[$urandom_range(0, 7)], 1'b0);
         else if (k == 1) side_evt(32'h0, 1'b1);
         run_txn(ops[$urandom_range(0, 12)], addrs[$urandom_range(0, 7)], $urandom,
                 $urandom_range(0, 3), r);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
